sram_bist_ctrl: RTL and testbench
=================================

SRAM_BIST_CTRL -- requirements
Module: sram_bist_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SRAM address width; words N = 2^ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32, SRAM data width.
REQ-003 Parameter WMASK_WIDTH, default 4, SRAM byte write-mask width.
REQ-004 Parameter READ_LATENCY, default 1: edges between the read-capture edge and the dout-sample edge.
REQ-005 The clock SHALL be a single clock named clk, and the reset SHALL be named rst_n, asynchronous and active-low.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle request to begin a test; honoured only in IDLE.
REQ-009 abort  input  1  terminate a running test.
REQ-010 bg_sel  input  2  data background: 00=all 0s, 01=0x55.., 10=0x33.., 11=0x0F.. (replicated to DATA_WIDTH).
REQ-011 mem_csb  output  1  SRAM chip select, active-low.
REQ-012 mem_web  output  1  SRAM write enable, active-low.
REQ-013 mem_wmask  output  WMASK_WIDTH  SRAM write mask.
REQ-014 mem_addr  output  ADDR_WIDTH  SRAM address.
REQ-015 mem_din  output  DATA_WIDTH  SRAM write data.
REQ-016 mem_dout  input  DATA_WIDTH  SRAM read data.
REQ-017 busy  output  1  test in progress (RUN or DRAIN).
REQ-018 done  output  1  sticky, set on normal completion; cleared by accepted start, abort or reset.
REQ-019 pass  output  1  done AND fail_count==0.
REQ-020 aborted  output  1  sticky, set when a test is aborted; cleared by accepted start or reset.
REQ-021 fail_addr  output  ADDR_WIDTH  address of first mismatch.
REQ-022 fail_elem  output  3  march element index (0-5) of first mismatch.
REQ-023 fail_count  output  8  mismatch count, saturating at 255.

Function
REQ-024 The block SHALL run March C- with D = background and ~D = complement: E0 up(w D); E1 up(r D, w ~D); E2 up(r ~D, w D); E3 down(r D, w ~D); E4 down(r ~D, w D); E5 up(r D).
REQ-025 Up order is 0..N-1, down order is N-1..0; the ops for one address are issued in consecutive cycles before the next address.
REQ-026 Each op SHALL occupy exactly one cycle with mem_csb=0; write: mem_web=0, mem_wmask=all ones; read: mem_web=1, mem_wmask=0.
REQ-027 Total issue cycles SHALL be 10*N (160 at default), with no idle cycles between ops or elements.
REQ-028 States: IDLE -> RUN on start; RUN -> DRAIN after the last op issues; DRAIN -> IDLE once the last read has been compared; abort in RUN/DRAIN -> IDLE.
REQ-029 bg_sel SHALL be latched when start is accepted; later changes SHALL NOT affect a running test.
REQ-030 With start sampled at edge E0, the first op SHALL be driven during the cycle after E0, and the last op SHALL be captured by the SRAM at edge E(10N).
REQ-031 A read captured at edge Ek SHALL have mem_dout compared at edge Ek+READ_LATENCY against expected data carried in a READ_LATENCY-deep pipeline, along with its address and element.
REQ-032 A mismatch is any bit difference over the full DATA_WIDTH; each mismatching read increments fail_count by one, saturating at 255.
REQ-033 On the first mismatch of a test, fail_addr and fail_elem SHALL be captured; later mismatches SHALL NOT change them.
REQ-034 done SHALL rise and busy SHALL fall at edge E(10N+READ_LATENCY+1).
REQ-035 start while busy SHALL be ignored; start and abort asserted together in IDLE SHALL be ignored (abort wins).
REQ-036 On abort, at the next edge: mem_csb=1, busy=0, done=0, aborted=1, and in-flight compares are discarded.
REQ-037 In IDLE: mem_csb=1, mem_web=1, mem_wmask=0, mem_addr=0, mem_din=0.
REQ-038 An accepted start SHALL clear fail_count, fail_addr, fail_elem, done and aborted.

Reset
REQ-039 rst_n low SHALL immediately force IDLE; mem_csb=1, mem_web=1, other mem_* =0; busy, done, pass, aborted =0; fail_addr, fail_elem, fail_count =0.
REQ-040 Reset asserted mid-test SHALL abandon the test without setting aborted; the first start after reset release SHALL run normally.

Verification
REQ-041 Reset: hold rst_n=0 -> all outputs at REQ-039 values, mem_csb=1 with no clock running.
REQ-042 Clean run, bg_sel=00, ideal 16x32 model, start at E0 -> first cycle csb=0, web=0, addr=0, din=0; 160 ops; done=1, pass=1, busy=0 at E162.
REQ-043 Model with bit 3 of address 5 stuck-at-1, bg_sel=00 -> fail_addr=5, fail_elem=1, fail_count=3 (E1, E3, E5 reads), pass=0.
REQ-044 bg_sel=01 -> E0 writes din=0x55555555; E1 writes 0xAAAAAAAA; bg_sel changed mid-run has no effect; pass=1.
REQ-045 abort at issue cycle 50 -> next edge csb=1, busy=0, done=0, aborted=1; start pulsed at cycle 20 is ignored.
REQ-046 rst_n pulsed low at issue cycle 100 -> outputs reset asynchronously, aborted=0; a new start then completes with pass=1.

Source files
------------

// File: rtl/sram_bist_ctrl_if.sv
// SRAM port bundle between the BIST controller and a single-port SRAM macro.
//   csb   : chip select, active-low (controller -> SRAM)
//   web   : write enable, active-low (controller -> SRAM)
//   wmask : byte write mask (controller -> SRAM)
//   addr  : word address (controller -> SRAM)
//   din   : write data (controller -> SRAM)
//   dout  : read data (SRAM -> controller)
interface sram_bist_ctrl_if #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 4
);
    logic                   csb;
    logic                   web;
    logic [WMASK_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  din;
    logic [DATA_WIDTH-1:0]  dout;

    modport master (
        output csb, web, wmask, addr, din,
        input  dout
    );

    modport slave (
        input  csb, web, wmask, addr, din,
        output dout
    );
endinterface

// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller for a single-port SRAM.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   mem         : SRAM bus (master side)
//   start       : one-cycle request to run a test (accepted only when idle)
//   abort       : terminate a running test
//   bg_sel      : data background, latched when start is accepted
//   busy        : test running (RUN or DRAIN)
//   done        : sticky normal-completion flag
//   pass        : done with no mismatches
//   aborted     : sticky abort flag
//   fail_addr   : address of first mismatch
//   fail_elem   : march element (0-5) of first mismatch
//   fail_count  : mismatch count, saturating at 255
//
// state | meaning
// IDLE  | waiting for start, SRAM deselected
// RUN   | issuing one march op per cycle (10*N ops)
// DRAIN | last op issued, waiting for outstanding read compares
module sram_bist_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int WMASK_WIDTH  = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_bist_ctrl_if.master      mem,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            bg_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  aborted,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [7:0]            fail_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            elem;
    } rd_t;

    localparam int CW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam int REP = (DATA_WIDTH + 7) / 8;

    state_t                state, state_nxt;
    logic [2:0]            elem;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  op;
    logic [1:0]            bg;
    logic [CW-1:0]         drain_cnt;

    logic                  start_ok, abort_ok;
    logic                  elem_down, single_op, addr_end, last_issue, drain_last;
    logic                  is_read, is_write, inv;
    logic [DATA_WIDTH-1:0] pattern, op_data;
    rd_t                   rd_in, rd_out;
    logic                  cmp_hit;

    function automatic logic [DATA_WIDTH-1:0] bg_word(input logic [1:0] s);
        logic [7:0]       b;
        logic [8*REP-1:0] rep;
        case (s)
            2'b00:   b = 8'h00;
            2'b01:   b = 8'h55;
            2'b10:   b = 8'h33;
            default: b = 8'h0F;
        endcase
        rep = {REP{b}};
        return rep[DATA_WIDTH-1:0];
    endfunction

    assign start_ok   = (state == IDLE) && start && !abort;
    assign abort_ok   = (state != IDLE) && abort;
    assign elem_down  = (elem == 3'd3) || (elem == 3'd4);
    assign single_op  = (elem == 3'd0) || (elem == 3'd5);
    assign addr_end   = elem_down ? (addr == '0) : (addr == ADDR_MAX);
    assign last_issue = (elem == 3'd5) && addr_end;
    assign drain_last = (drain_cnt == '0);

    // First op of E1..E5 is a read; E0 and the second op of E1..E4 are writes.
    // Reads expect ~D in E2/E4, writes store ~D in E1/E3.
    assign is_read  = (elem != 3'd0) && !op;
    assign is_write = (state == RUN) && !is_read;
    assign inv      = is_read ? ((elem == 3'd2) || (elem == 3'd4))
                              : ((elem == 3'd1) || (elem == 3'd3));
    assign pattern  = bg_word(bg);
    assign op_data  = inv ? ~pattern : pattern;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (abort) state_nxt = IDLE;
                     else if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (abort || drain_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem.csb   = 1'b1;
        mem.web   = 1'b1;
        mem.wmask = '0;
        mem.addr  = '0;
        mem.din   = '0;
        if (state == RUN) begin
            mem.csb  = 1'b0;
            mem.addr = addr;
            if (is_write) begin
                mem.web   = 1'b0;
                mem.wmask = '1;
                mem.din   = op_data;
            end
        end
    end

    // Address/element sequencer. E3 and E4 walk downward, so the element
    // boundaries into E3 and E4 reload the top address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem      <= '0;
            addr      <= '0;
            op        <= 1'b0;
            bg        <= '0;
            drain_cnt <= '0;
        end else if (start_ok) begin
            elem <= '0;
            addr <= '0;
            op   <= 1'b0;
            bg   <= bg_sel;
        end else if (state == RUN && !abort) begin
            if (!single_op && !op) begin
                op <= 1'b1;
            end else begin
                op <= 1'b0;
                if (addr_end) begin
                    elem <= elem + 3'd1;
                    addr <= ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_MAX : '0;
                end else begin
                    addr <= elem_down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
                end
            end
            if (last_issue) drain_cnt <= CW'(READ_LATENCY);
        end else if (state == DRAIN && !drain_last) begin
            drain_cnt <= drain_cnt - CW'(1);
        end
    end

    // Expected-read pipeline: one stage per cycle of SRAM read latency.
    assign rd_in = '{vld: (state == RUN) && is_read, data: op_data, addr: addr, elem: elem};

    for (genvar g = 0; g < READ_LATENCY; g++) begin : g_pipe
        rd_t q;
        if (g == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)        q <= '0;
                else if (abort_ok) q <= '0;
                else               q <= rd_in;
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)        q <= '0;
                else if (abort_ok) q <= '0;
                else               q <= g_pipe[g-1].q;
            end
        end
    end

    assign rd_out  = g_pipe[READ_LATENCY-1].q;
    assign cmp_hit = rd_out.vld && !abort_ok && (mem.dout != rd_out.data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done       <= 1'b0;
            aborted    <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_count <= '0;
        end else if (start_ok) begin
            done       <= 1'b0;
            aborted    <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_count <= '0;
        end else begin
            if (abort)    done    <= 1'b0;
            if (abort_ok) aborted <= 1'b1;
            if (state == DRAIN && drain_last && !abort) done <= 1'b1;
            if (cmp_hit) begin
                // A zero count means no mismatch yet in this test.
                if (fail_count == 8'd0) begin
                    fail_addr <= rd_out.addr;
                    fail_elem <= rd_out.elem;
                end
                if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            end
        end
    end

    assign busy = (state != IDLE);
    assign pass = done && (fail_count == 8'd0);

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Testbench for sram_bist_ctrl: behavioural SRAM with an optional single
// stuck-at bit, March C- reference model built from the element table,
// table-driven fault vectors, randomized runs and hand-written corner cases.
module tb_sram_bist_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int RL    = 1;
    localparam int N     = 1 << AW;
    localparam int ISSUE = 10 * N;

    // March C- table: ops per element, direction, and op codes
    // (0 = w D, 1 = w ~D, 2 = r D, 3 = r ~D).
    localparam int M_NOPS [6]    = '{1, 2, 2, 2, 2, 1};
    localparam int M_DOWN [6]    = '{0, 0, 0, 1, 1, 0};
    localparam int M_OP   [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};

    typedef struct {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
        int            elem;
    } op_t;

    typedef struct {
        logic [1:0] bg;
        logic       fen;
        int         fa;
        int         fb;
        logic       fv;
        int         cnt;
        int         faddr;
        int         felem;
        logic       pass;
    } vec_t;

    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          rst_n, start, abort;
    logic [1:0]    bg_sel;
    logic          busy, done, pass, aborted;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [7:0]    fail_count;

    sram_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) mem_if ();

    sram_bist_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .READ_LATENCY(RL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (mem_if),
        .start      (start),
        .abort      (abort),
        .bg_sel     (bg_sel),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .aborted    (aborted),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_count (fail_count)
    );

    always #5 if (clk_en) clk = ~clk;

    // ---------------- behavioural SRAM ----------------
    logic [DW-1:0] mem_arr [N];
    logic          fault_en = 1'b0;
    logic          fault_val = 1'b0;
    int            fault_addr = 0;
    int            fault_bit = 0;
    logic          cap_vld = 1'b0, cap_wr = 1'b0;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_din;
    logic [MW-1:0] cap_mask;
    op_t           trace [$];
    op_t           exp_ops [$];

    int tests_run = 0;
    int tests_failed = 0;

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] w, input int a);
        logic [DW-1:0] m;
        m = DW'(1) << fault_bit;
        if (fault_en && a == fault_addr) return fault_val ? (w | m) : (w & ~m);
        return w;
    endfunction

    always @(negedge clk) begin
        op_t r;
        cap_vld  = !mem_if.csb;
        cap_wr   = !mem_if.web;
        cap_addr = mem_if.addr;
        cap_din  = mem_if.din;
        cap_mask = mem_if.wmask;
        if (!mem_if.csb) begin
            r.rd = mem_if.web; r.addr = mem_if.addr; r.data = mem_if.din;
            r.mask = mem_if.wmask; r.elem = 0;
            trace.push_back(r);
        end
    end

    always @(posedge clk) begin
        if (cap_vld) begin
            if (cap_wr) begin
                for (int b = 0; b < MW; b++)
                    if (cap_mask[b]) mem_arr[cap_addr][8*b +: 8] = cap_din[8*b +: 8];
            end else begin
                mem_if.dout <= faulty(mem_arr[cap_addr], int'(cap_addr));
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] bg_word(input logic [1:0] s);
        case (s)
            2'b00:   return 32'h0000_0000;
            2'b01:   return 32'h5555_5555;
            2'b10:   return 32'h3333_3333;
            default: return 32'h0F0F_0F0F;
        endcase
    endfunction

    function automatic void build_expected(input logic [1:0] bg);
        logic [DW-1:0] d;
        op_t r;
        d = bg_word(bg);
        exp_ops.delete();
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < N; i++)
                for (int o = 0; o < M_NOPS[e]; o++) begin
                    r.elem = e;
                    r.addr = AW'(M_DOWN[e] != 0 ? N - 1 - i : i);
                    r.rd   = (M_OP[e][o] >= 2);
                    r.data = (M_OP[e][o] % 2 == 1) ? ~d : d;
                    r.mask = r.rd ? '0 : '1;
                    exp_ops.push_back(r);
                end
    endfunction

    function automatic void model_run(output int cnt, output int faddr, output int felem);
        logic [DW-1:0] m [N];
        cnt = 0; faddr = 0; felem = 0;
        foreach (exp_ops[i]) begin
            if (!exp_ops[i].rd) m[exp_ops[i].addr] = exp_ops[i].data;
            else if (faulty(m[exp_ops[i].addr], int'(exp_ops[i].addr)) != exp_ops[i].data) begin
                if (cnt == 0) begin faddr = int'(exp_ops[i].addr); felem = exp_ops[i].elem; end
                if (cnt < 255) cnt++;
            end
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic bit op_match(input op_t t, input op_t e);
        if (t.rd !== e.rd || t.addr !== e.addr || t.mask !== e.mask) return 0;
        if (!e.rd && t.data !== e.data) return 0;
        return 1;
    endfunction

    task automatic check_trace(input string name, input int n);
        int bad = -1;
        tests_run++;
        for (int i = 0; i < n && i < trace.size(); i++)
            if (bad < 0 && !op_match(trace[i], exp_ops[i])) bad = i;
        if (trace.size() != n || bad >= 0) begin
            tests_failed++;
            $display("FAIL %s: %0d ops logged (required %0d), first wrong op index %0d",
                     name, trace.size(), n, bad);
        end
    endtask

    // Starts a test (start sampled at E0) and waits for done; cycles = edges after E0.
    task automatic run_bist(input logic [1:0] bg, output int cycles);
        trace.delete();
        @(negedge clk);
        bg_sel = bg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bg_sel = 2'($urandom);
        check("first_csb", mem_if.csb, 0);
        check("first_op_web", mem_if.web, 0);
        check("first_addr", mem_if.addr, 0);
        check("first_din", mem_if.din, bg_word(bg));
        check("start_aborted_clr", aborted, 0);
        cycles = 0;
        while (done !== 1'b1 && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("done_edge", cycles, ISSUE + RL + 1);
        check("busy_low_at_done", busy, 0);
    endtask

    vec_t vecs [6];
    int   cyc, mc, ma, me;

    initial begin
        vecs[0] = '{2'd0, 1'b0,  0, 0, 1'b0, 0,  0, 0, 1'b1};
        vecs[1] = '{2'd0, 1'b1,  5, 3, 1'b1, 3,  5, 1, 1'b0};
        vecs[2] = '{2'd0, 1'b1,  9, 0, 1'b0, 2,  9, 2, 1'b0};
        vecs[3] = '{2'd1, 1'b1, 15, 0, 1'b1, 2, 15, 2, 1'b0};
        vecs[4] = '{2'd3, 1'b1,  0, 4, 1'b1, 3,  0, 1, 1'b0};
        vecs[5] = '{2'd2, 1'b1,  7, 2, 1'b0, 2,  7, 2, 1'b0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; bg_sel = 2'b00;

        // Reset with no clock running.
        #10;
        check("rst_csb", mem_if.csb, 1);
        check("rst_web", mem_if.web, 1);
        check("rst_mem_other", {mem_if.wmask, mem_if.addr, mem_if.din}, 0);
        check("rst_status", {busy, done, pass, aborted}, 0);
        check("rst_fail_info", {fail_addr, fail_elem, fail_count}, 0);

        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Clean run, background 00.
        fault_en = 1'b0;
        build_expected(2'b00);
        run_bist(2'b00, cyc);
        check_trace("clean_trace", ISSUE);
        check("clean_done", done, 1);
        check("clean_pass", pass, 1);

        // Background 01 with bg_sel changing mid-run.
        build_expected(2'b01);
        run_bist(2'b01, cyc);
        check_trace("bg01_trace", ISSUE);
        check("bg01_e0_din", trace.size() > 0 ? trace[0].data : 32'hx, 32'h5555_5555);
        check("bg01_e1_din", trace.size() > N + 1 ? trace[N+1].data : 32'hx, 32'hAAAA_AAAA);
        check("bg01_pass", pass, 1);

        // Start together with abort while idle is ignored; abort clears done.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        check("idle_start_abort_busy", busy, 0);
        check("idle_start_abort_csb", mem_if.csb, 1);
        check("idle_abort_done_clr", done, 0);
        start = 1'b0; abort = 1'b0;

        // Abort at issue cycle 50; start pulsed at cycle 20 is ignored.
        build_expected(2'b00);
        trace.delete();
        @(negedge clk);
        bg_sel = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_csb", mem_if.csb, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_flag", aborted, 1);
        check_trace("abort_prefix", 51);
        repeat (3) @(posedge clk);
        #1 check("abort_stays_idle", {busy, mem_if.csb, aborted}, 3'b011);

        // Reset mid-test at issue cycle 100 with a fault already counted.
        fault_en = 1'b1; fault_addr = 0; fault_bit = 0; fault_val = 1'b0;
        @(negedge clk);
        bg_sel = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1 check("pre_rst_fail_count", fail_count, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_csb_web", {mem_if.csb, mem_if.web}, 2'b11);
        check("mid_rst_mem_other", {mem_if.wmask, mem_if.addr, mem_if.din}, 0);
        check("mid_rst_status", {busy, done, pass, aborted}, 0);
        check("mid_rst_fail_info", {fail_addr, fail_elem, fail_count}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fault_en = 1'b0;
        build_expected(2'b00);
        run_bist(2'b00, cyc);
        check_trace("post_rst_trace", ISSUE);
        check("post_rst_pass", pass, 1);

        // Table-driven fault vectors.
        for (int v = 0; v < 6; v++) begin
            fault_en = vecs[v].fen; fault_addr = vecs[v].fa;
            fault_bit = vecs[v].fb; fault_val = vecs[v].fv;
            build_expected(vecs[v].bg);
            run_bist(vecs[v].bg, cyc);
            check_trace("vec_trace", ISSUE);
            check("vec_fail_count", fail_count, vecs[v].cnt);
            check("vec_fail_addr", fail_addr, vecs[v].faddr);
            check("vec_fail_elem", fail_elem, vecs[v].felem);
            check("vec_pass", pass, vecs[v].pass);
        end

        // Randomized backgrounds and faults against the reference model.
        for (int r = 0; r < 8; r++) begin
            logic [1:0] bg;
            bg = 2'($urandom_range(0, 3));
            fault_en   = 1'($urandom_range(0, 3) != 0);
            fault_addr = $urandom_range(0, N - 1);
            fault_bit  = $urandom_range(0, DW - 1);
            fault_val  = 1'($urandom_range(0, 1));
            build_expected(bg);
            model_run(mc, ma, me);
            run_bist(bg, cyc);
            check_trace("rnd_trace", ISSUE);
            check("rnd_fail_count", fail_count, mc);
            check("rnd_fail_addr", fail_addr, ma);
            check("rnd_fail_elem", fail_elem, me);
            check("rnd_pass", pass, (mc == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
